// File: rtl/fpu_cvt_arbiter_pkg.sv
// Shared definitions for the FP->integer convert arbiter: convert opcodes and slot state.
package fpu_cvt_arbiter_pkg;

    localparam logic [7:0] fop_cvtD   = 8'h30;
    localparam logic [7:0] fop_cvtE   = 8'h31;
    localparam logic [7:0] fop_cvtS   = 8'h32;
    localparam logic [7:0] fop_cvt32S = 8'h33;
    localparam logic [7:0] fop_cvt32D = 8'h34;
    localparam logic [7:0] fop_tblD   = 8'h35;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_PEND  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/fpu_cvt_arbiter_if.sv
// Request, converter and response signals of the convert arbiter, grouped for port hookup.
interface fpu_cvt_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 82,
    parameter int RES_W  = 65,
    parameter int TAG_W  = 14
);
    logic [NREQ-1:0]        req_vld;
    logic [NREQ-1:0]        req_rdy;
    logic [NREQ*8-1:0]      req_op;
    logic [NREQ*DATA_W-1:0] req_A;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic                   flush;
    logic                   cvt_hold;
    logic                   cvt_en;
    logic [7:0]             cvt_op;
    logic [DATA_W-1:0]      cvt_A;
    logic [RES_W-1:0]       cvt_res;
    logic                   cvt_alt;
    logic [NREQ-1:0]        rsp_vld;
    logic [RES_W-1:0]       rsp_res;
    logic [TAG_W-1:0]       rsp_tag;
    logic                   rsp_alt;

    modport slave (
        input  req_vld, req_op, req_A, req_tag, flush, cvt_hold, cvt_res, cvt_alt,
        output req_rdy, cvt_en, cvt_op, cvt_A, rsp_vld, rsp_res, rsp_tag, rsp_alt
    );

    modport master (
        output req_vld, req_op, req_A, req_tag, flush, cvt_hold, cvt_res, cvt_alt,
        input  req_rdy, cvt_en, cvt_op, cvt_A, rsp_vld, rsp_res, rsp_tag, rsp_alt
    );

endinterface

// File: rtl/fpu_cvt_arbiter_rr_arb_n.sv
// N-wide round-robin picker: first pending requester at or after ptr_i, as one-hot plus index.
module rr_arb_n #(
    parameter int N = 3
) (
    input  logic [N-1:0]         pend_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] win_o
);
    localparam int IDW = $clog2(N);

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        gnt_o = '0;
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr_i) + k) % N);
            if (!found && pend_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                win_o      = idx;
            end
        end
    end

endmodule

// File: rtl/fpu_cvt_arbiter.sv
// Shares one fixed-latency FP->int converter among NREQ issue ports: one buffered op per port,
// round-robin issue, stall-aware in-flight tracking and per-port result return.
module fpu_cvt_arbiter
    import fpu_cvt_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = 82,
    parameter int RES_W  = 65,
    parameter int TAG_W  = 14,
    parameter int LAT    = 2
) (
    input logic              clk,
    input logic              rst,
    fpu_cvt_arbiter_if.slave bus
);
    localparam int             IDW     = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef struct packed {
        logic             vld;
        logic [IDW-1:0]   id;
        logic [TAG_W-1:0] tag;
    } cvt_trk_t;

    slot_state_e       slot_q [NREQ];
    slot_state_e       slot_d [NREQ];
    logic [7:0]        sop_q  [NREQ];
    logic [DATA_W-1:0] sa_q   [NREQ];
    logic [TAG_W-1:0]  stag_q [NREQ];

    logic [IDW-1:0]    rr_q, rr_d;
    logic [NREQ-1:0]   pend, gnt_raw, gnt, rdy, accept;
    logic [IDW-1:0]    win;
    logic              any_gnt;

    logic              en_q;
    logic [7:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [IDW-1:0]    iss_id_q;
    logic [TAG_W-1:0]  iss_tag_q;

    cvt_trk_t          trk_q [LAT];
    logic              retire;
    logic [NREQ-1:0]   ret_oh;

    logic [NREQ-1:0]   rsp_vld_q;
    logic [RES_W-1:0]  rsp_res_q;
    logic [TAG_W-1:0]  rsp_tag_q;
    logic              rsp_alt_q;

    rr_arb_n #(.N(NREQ)) u_rr (
        .pend_i (pend),
        .ptr_i  (rr_q),
        .gnt_o  (gnt_raw),
        .win_o  (win)
    );

    // A slot granted this cycle can take a new op in the same cycle; flush ignores requests.
    always_comb begin
        pend   = '0;
        rdy    = '0;
        accept = '0;
        gnt    = (bus.cvt_hold || bus.flush) ? '0 : gnt_raw;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]   = (slot_q[i] == SLOT_PEND);
            rdy[i]    = bus.flush || (slot_q[i] == SLOT_EMPTY) || gnt[i];
            accept[i] = bus.req_vld[i] && rdy[i] && !bus.flush;
        end
        any_gnt = |gnt;
    end

    always_comb begin
        rr_d = rr_q;
        if (any_gnt) begin
            rr_d = (win == LAST_ID) ? '0 : win + 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            slot_d[i] = slot_q[i];
            if (bus.flush) begin
                slot_d[i] = SLOT_EMPTY;
            end else if (accept[i]) begin
                slot_d[i] = SLOT_PEND;
            end else if (gnt[i]) begin
                slot_d[i] = SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= SLOT_EMPTY;
            end
        end else begin
            rr_q <= rr_d;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                sop_q[i]  <= bus.req_op[i*8 +: 8];
                sa_q[i]   <= bus.req_A[i*DATA_W +: DATA_W];
                stag_q[i] <= bus.req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // Issue stage: holds its op while the converter is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q      <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            iss_id_q  <= '0;
            iss_tag_q <= '0;
        end else if (bus.flush) begin
            en_q <= 1'b0;
        end else if (!bus.cvt_hold) begin
            en_q <= any_gnt;
            if (any_gnt) begin
                op_q      <= sop_q[win];
                a_q       <= sa_q[win];
                iss_id_q  <= win;
                iss_tag_q <= stag_q[win];
            end
        end
    end

    // Tracking pipe: last stage lines up with cvt_res of the same op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < LAT; s++) begin
                trk_q[s] <= '0;
            end
        end else if (bus.flush) begin
            for (int s = 0; s < LAT; s++) begin
                trk_q[s].vld <= 1'b0;
            end
        end else if (!bus.cvt_hold) begin
            trk_q[0] <= {en_q, iss_id_q, iss_tag_q};
            for (int s = 1; s < LAT; s++) begin
                trk_q[s] <= trk_q[s-1];
            end
        end
    end

    always_comb begin
        retire = trk_q[LAT-1].vld && !bus.cvt_hold && !bus.flush;
        ret_oh = '0;
        ret_oh[trk_q[LAT-1].id] = 1'b1;
    end

    // Response stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld_q <= '0;
            rsp_res_q <= '0;
            rsp_tag_q <= '0;
            rsp_alt_q <= 1'b0;
        end else begin
            rsp_vld_q <= '0;
            if (retire) begin
                rsp_vld_q <= ret_oh;
                rsp_res_q <= bus.cvt_res;
                rsp_tag_q <= trk_q[LAT-1].tag;
                rsp_alt_q <= bus.cvt_alt;
            end
        end
    end

    assign bus.req_rdy = rdy;
    assign bus.cvt_en  = en_q && !bus.cvt_hold && !bus.flush;
    assign bus.cvt_op  = op_q;
    assign bus.cvt_A   = a_q;
    assign bus.rsp_vld = rsp_vld_q & {NREQ{~bus.flush}};
    assign bus.rsp_res = rsp_res_q;
    assign bus.rsp_tag = rsp_tag_q;
    assign bus.rsp_alt = rsp_alt_q;

endmodule
